tmcounter_arb: RTL and testbench
================================

TMCOUNTER_ARB -- requirements
Module: tmcounter_arb

Interface
REQ-001 Parameter LOCK_TMO, 64: idle cycles after which a held lock is forcibly released (2..255).
REQ-002 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-003 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 m0_adr_i/m1_adr_i  in  3  master 0 (CPU) / master 1 (auxiliary) address.
REQ-005 m0_dat_i/m1_dat_i  in  8  master write data.
REQ-006 m0_dat_o/m1_dat_o  out  8  master read data.
REQ-007 m0_we_i/m1_we_i, m0_stb_i/m1_stb_i  in  1  master write enable, strobe.
REQ-008 m0_ack_o/m1_ack_o  out  1  master acknowledge.
REQ-009 s_adr_o 3, s_dat_o 8, s_we_o 1, s_stb_o 1  out  timer-slave bus.
REQ-010 s_dat_i 8, s_ack_i 1  in  timer-slave read data, acknowledge (ack may stall many cycles during the microsecond blocker).
REQ-011 gnt_o  out  2  one-hot current owner; 00 when none.

Function
REQ-012 FSM states IDLE, BUSY, LOCKED; encoding is free.
REQ-013 IDLE: if any stb high, register winner into gnt_o and go BUSY next cycle; no slave strobe in IDLE.
REQ-014 Arbitration round-robin: on simultaneous requests, win goes to master not granted last; after reset m0 wins first.
REQ-015 BUSY: s_adr_o/s_dat_o/s_we_o/s_stb_o combinationally driven from owner; s_ack_i and s_dat_i routed combinationally to owner only.
REQ-016 Non-owner: ack_o=0, dat_o=0 at all times; its request stays pending, never dropped.
REQ-017 BUSY with s_ack_i high: transfer complete; next state LOCKED if lock-start condition (REQ-019) holds, else IDLE with gnt_o=00.
REQ-018 Owner stb deasserted before ack (abort): s_stb_o drops same cycle, next state IDLE, lock (if any) released.
REQ-019 Lock start: owner completes read (we=0) of address 0 or 4.
REQ-020 LOCKED: slave bus idle; owner stb returns to BUSY next cycle with lock retained; non-owner never granted.
REQ-021 Lock end: owner completes read of address 3 or 7, or completes any write; then IDLE.
REQ-022 Lock timeout: 8-bit counter cleared on lock entry and every owner transfer, increments each LOCKED cycle without owner stb; reaching LOCK_TMO forces IDLE, gnt_o=00.
REQ-023 Blocker write (we=1, address 7) lasts until s_ack_i; no timeout in BUSY; other master waits.
REQ-024 Minimum cost: request-to-s_stb_o latency 1 cycle from IDLE; back-to-back transfers by the same master incur one IDLE cycle unless locked.

Reset
REQ-025 Reset asserted: state IDLE, gnt_o=00, round-robin pointer to m0, timeout counter 0, s_stb_o=0, both ack_o=0 immediately and asynchronously.
REQ-026 Reset mid-transfer or mid-lock: transfer abandoned, no ack delivered, lock lost.

Configuration
REQ-027 Macro TMCOUNTER_ARB_LOCK_EN defined: LOCKED state and timeout counter built per REQ-019..022.
REQ-028 Macro absent: no LOCKED state, no counter, every completion returns to IDLE; LOCK_TMO ignored.

Structure
REQ-029 Shared package holds FSM state constants, timer address constants (US_B0=0, US_B3=3, MS_B0=4, MS_B3=7) and default LOCK_TMO.
REQ-030 One sub-module natural: tmarb_rr, the two-requester round-robin picker (requests, last-grant in; one-hot grant out).
REQ-031 Remainder (FSM, mux, lock timer) flat in tmcounter_arb.

Verification
REQ-032 Simultaneous m0/m1 stb from reset, slave acks in 1 cycle -> m0 served first, m1 next; gnt_o 01 then 10.
REQ-033 m1 reads addresses 0,1,2,3 while m0 holds stb continuously -> m0 not granted until m1 address 3 acked; slave sees 0,1,2,3 contiguous.
REQ-034 m1 reads address 4 then goes silent, LOCK_TMO=16 -> lock dropped 16 cycles later, m0 granted next.
REQ-035 m0 writes 0x05 to address 7, slave holds ack low 120 cycles -> m1 waits, m0_ack_o high exactly on slave ack cycle.
REQ-036 Reset pulsed while LOCKED and m0 stb high -> gnt_o=00 during reset, m0 granted first after release, no ack lost or duplicated.
REQ-037 Build without TMCOUNTER_ARB_LOCK_EN, repeat REQ-033 -> m0 interleaves between m1 bytes.

Source files
------------

// File: rtl/tmcounter_arb_pkg.sv
// Shared definitions for the timer-slave arbiter: FSM states, timer
// register addresses and lock helpers.
package tmcounter_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Microsecond and millisecond counter byte addresses.
    localparam logic [2:0] US_B0 = 3'd0;
    localparam logic [2:0] US_B3 = 3'd3;
    localparam logic [2:0] MS_B0 = 3'd4;
    localparam logic [2:0] MS_B3 = 3'd7;

    localparam int unsigned LOCK_TMO_DEFAULT = 64;

    // Reading the low byte of a counter latches the multi-byte read sequence.
    function automatic logic lock_starts(input logic we, input logic [2:0] adr);
        return !we && ((adr == US_B0) || (adr == MS_B0));
    endfunction

    // Reading the top byte, or any write, finishes the sequence.
    function automatic logic lock_ends(input logic we, input logic [2:0] adr);
        return we || (adr == US_B3) || (adr == MS_B3);
    endfunction

endpackage

// File: rtl/tmcounter_arb_rr.sv
// Two-requester round-robin picker: with both requesting, the master that
// was not granted last wins.
module tmarb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,   // 1: master 1 was granted last
    output logic [1:0] gnt_o
);

    // Combinational one-hot pick.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/tmcounter_arb.sv
// Two-master arbiter in front of the timer slave. A master that reads the
// low byte of a counter keeps the slave until it reads the top byte, writes,
// aborts, or stays quiet for LOCK_TMO cycles.
// Optional feature: define TMCOUNTER_ARB_LOCK_EN to build the lock logic;
// without it every completed transfer returns to IDLE.
//
// state     | meaning
// ST_IDLE   | no owner, picking a winner among strobing masters
// ST_BUSY   | owner's transfer presented to the slave
// ST_LOCKED | owner holds the slave between transfers, bus idle
module tmcounter_arb
    import tmcounter_arb_pkg::*;
#(
    parameter int unsigned LOCK_TMO = LOCK_TMO_DEFAULT
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic [2:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic [7:0] m0_dat_o,
    input  logic       m0_we_i,
    input  logic       m0_stb_i,
    output logic       m0_ack_o,
    input  logic [2:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic [7:0] m1_dat_o,
    input  logic       m1_we_i,
    input  logic       m1_stb_i,
    output logic       m1_ack_o,
    output logic [2:0] s_adr_o,
    output logic [7:0] s_dat_o,
    output logic       s_we_o,
    output logic       s_stb_o,
    input  logic [7:0] s_dat_i,
    input  logic       s_ack_i,
    output logic [1:0] gnt_o
);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [1:0] req;
    logic [1:0] pick;
    logic       own_stb;
    logic       own_we;
    logic [2:0] own_adr;
    logic [7:0] own_dat;

`ifdef TMCOUNTER_ARB_LOCK_EN
    localparam logic [7:0] TMO_LIMIT = 8'(LOCK_TMO);
    logic       lock_q, lock_d;
    logic [7:0] tmo_q, tmo_d;
`else
    logic unused_lock_tmo;
    assign unused_lock_tmo = ^32'(LOCK_TMO);
`endif

    assign req   = {m1_stb_i, m0_stb_i};
    assign gnt_o = gnt_q;

    tmarb_rr u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Select the current owner's request signals.
    always_comb begin
        own_stb = 1'b0;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        if (gnt_q[1]) begin
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
        end else if (gnt_q[0]) begin
            own_stb = m0_stb_i;
        end
    end

    // Slave bus and master return paths; only the owner in BUSY sees the slave.
    always_comb begin
        s_stb_o  = 1'b0;
        s_adr_o  = 3'd0;
        s_dat_o  = 8'd0;
        s_we_o   = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = 8'd0;
        m1_dat_o = 8'd0;
        if (state_q == ST_BUSY) begin
            s_stb_o  = own_stb;
            s_adr_o  = own_adr;
            s_dat_o  = own_dat;
            s_we_o   = own_we;
            m0_ack_o = gnt_q[0] & own_stb & s_ack_i;
            m1_ack_o = gnt_q[1] & own_stb & s_ack_i;
            m0_dat_o = gnt_q[0] ? s_dat_i : 8'd0;
            m1_dat_o = gnt_q[1] ? s_dat_i : 8'd0;
        end
    end

    // Next-state logic for ownership, round-robin pointer and lock timer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
`ifdef TMCOUNTER_ARB_LOCK_EN
        lock_d  = lock_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                    last_d  = pick[1];
`ifdef TMCOUNTER_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end
            end
            ST_BUSY: begin
                if (!own_stb) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
`ifdef TMCOUNTER_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else if (s_ack_i) begin
`ifdef TMCOUNTER_ARB_LOCK_EN
                    tmo_d = 8'd0;
                    if (lock_ends(own_we, own_adr)) begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                        lock_d  = 1'b0;
                    end else if (lock_q || lock_starts(own_we, own_adr)) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                    end
`else
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
`endif
                end
            end
`ifdef TMCOUNTER_ARB_LOCK_EN
            ST_LOCKED: begin
                if (own_stb) begin
                    state_d = ST_BUSY;
                    tmo_d   = 8'd0;
                end else if (tmo_q + 8'd1 == TMO_LIMIT) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    lock_d  = 1'b0;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d   = tmo_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State, grant and round-robin registers; pointer resets so m0 wins first.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef TMCOUNTER_ARB_LOCK_EN
    // Lock flag and idle-timeout counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            lock_q <= 1'b0;
            tmo_q  <= 8'd0;
        end else begin
            lock_q <= lock_d;
            tmo_q  <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_tmcounter_arb.sv
// Bench for tmcounter_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an ownership-level model.
module tb_tmcounter_arb;

    localparam int TMO = 16;
`ifdef TMCOUNTER_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        int adr;
        int we;
        int dat;
        int pre;
        int abort_after;
    } txn_t;

    logic       wb_clk_i  = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic [2:0] m0_adr_i  = 3'd0;
    logic [7:0] m0_dat_i  = 8'd0;
    logic       m0_we_i   = 1'b0;
    logic       m0_stb_i  = 1'b0;
    logic [2:0] m1_adr_i  = 3'd0;
    logic [7:0] m1_dat_i  = 8'd0;
    logic       m1_we_i   = 1'b0;
    logic       m1_stb_i  = 1'b0;
    logic [7:0] s_dat_i   = 8'd0;
    logic       s_ack_i   = 1'b0;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack_o, m1_ack_o;
    logic [2:0] s_adr_o;
    logic [7:0] s_dat_o;
    logic       s_we_o, s_stb_o;
    logic [1:0] gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    txn_t mq[2][$];
    bit   act[2];
    bit   acked[2];
    int   gapc[2];
    int   actc[2];
    int   nack[2];

    int sdelay    = 0;
    int swait     = 0;
    bit rand_mode = 1'b0;
    int xlog[$];

    // model state: owner 0 none, 1 m0, 2 m1
    int m_owner = 0;
    int m_xfer  = 0;
    int m_held  = 0;
    int m_quiet = 0;
    int m_last  = 2;

    tmcounter_arb #(.LOCK_TMO(TMO)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m0_we_i   (m0_we_i),
        .m0_stb_i  (m0_stb_i),
        .m0_ack_o  (m0_ack_o),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_dat_o  (m1_dat_o),
        .m1_we_i   (m1_we_i),
        .m1_stb_i  (m1_stb_i),
        .m1_ack_o  (m1_ack_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_we_o    (s_we_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .gnt_o     (gnt_o)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
        end
    endtask

    function automatic txn_t mk(input int adr, input int we, input int dat, input int pre, input int ab);
        txn_t t;
        t.adr = adr; t.we = we; t.dat = dat; t.pre = pre; t.abort_after = ab;
        return t;
    endfunction

    // Master engines: advance one cycle after each rising edge.
    initial begin
        forever begin
            @(posedge wb_clk_i);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (acked[i]) begin
                        act[i] = 1'b0;
                        nack[i]++;
                        void'(mq[i].pop_front());
                    end else begin
                        actc[i]++;
                        if (mq[i][0].abort_after > 0 && actc[i] >= mq[i][0].abort_after) begin
                            act[i] = 1'b0;
                            void'(mq[i].pop_front());
                        end
                    end
                end
                if (!act[i] && mq[i].size() > 0) begin
                    if (gapc[i] >= mq[i][0].pre) begin
                        act[i]  = 1'b1;
                        gapc[i] = 0;
                        actc[i] = 0;
                    end else begin
                        gapc[i]++;
                    end
                end
            end
            m0_stb_i = act[0];
            m0_adr_i = act[0] ? 3'(mq[0][0].adr) : 3'($urandom);
            m0_we_i  = act[0] ? 1'(mq[0][0].we)  : 1'($urandom);
            m0_dat_i = act[0] ? 8'(mq[0][0].dat) : 8'($urandom);
            m1_stb_i = act[1];
            m1_adr_i = act[1] ? 3'(mq[1][0].adr) : 3'($urandom);
            m1_we_i  = act[1] ? 1'(mq[1][0].we)  : 1'($urandom);
            m1_dat_i = act[1] ? 8'(mq[1][0].dat) : 8'($urandom);
        end
    end

    // Slave responder: ack after sdelay strobed cycles, random read data.
    initial begin
        forever begin
            @(posedge wb_clk_i);
            #2;
            s_ack_i = s_stb_o && (swait >= sdelay);
            s_dat_i = 8'($urandom);
        end
    end

    // Compare process: model prediction vs DUT on every falling edge.
    always @(negedge wb_clk_i) begin : cmp
        int ms[2], ma[2], mw[2], md[2];
        int o, nxt, active, e_ack, e_dat;
        acked[0] = m0_ack_o;
        acked[1] = m1_ack_o;
        if (!wb_rst_ni) begin
            chk("rst_gnt", int'(gnt_o), 0);
            chk("rst_s_stb", int'(s_stb_o), 0);
            chk("rst_acks", int'({m1_ack_o, m0_ack_o}), 0);
            m_owner = 0; m_xfer = 0; m_held = 0; m_quiet = 0; m_last = 2;
            swait = 0;
        end else begin
            ms[0] = int'(m0_stb_i); ma[0] = int'(m0_adr_i); mw[0] = int'(m0_we_i); md[0] = int'(m0_dat_i);
            ms[1] = int'(m1_stb_i); ma[1] = int'(m1_adr_i); mw[1] = int'(m1_we_i); md[1] = int'(m1_dat_i);
            o = (m_owner > 0) ? m_owner - 1 : 0;
            active = (m_owner > 0 && m_xfer == 1 && ms[o] == 1) ? 1 : 0;
            chk("gnt", int'(gnt_o), (m_owner == 0) ? 0 : (m_owner == 1 ? 1 : 2));
            chk("s_stb", int'(s_stb_o), active);
            if (active == 1) begin
                chk("s_adr", int'(s_adr_o), ma[o]);
                chk("s_we", int'(s_we_o), mw[o]);
                chk("s_dat", int'(s_dat_o), md[o]);
            end
            for (int i = 0; i < 2; i++) begin
                e_ack = (m_owner == i + 1 && active == 1 && s_ack_i) ? 1 : 0;
                e_dat = (m_owner == i + 1 && m_xfer == 1) ? int'(s_dat_i) : 0;
                chk(i == 0 ? "m0_ack" : "m1_ack", i == 0 ? int'(m0_ack_o) : int'(m1_ack_o), e_ack);
                chk(i == 0 ? "m0_dat" : "m1_dat", i == 0 ? int'(m0_dat_o) : int'(m1_dat_o), e_dat);
            end
            // advance the ownership model
            if (m_owner == 0) begin
                if (ms[0] == 1 || ms[1] == 1) begin
                    if (ms[0] == 1 && ms[1] == 1) nxt = (m_last == 1) ? 2 : 1;
                    else nxt = (ms[0] == 1) ? 1 : 2;
                    m_owner = nxt; m_last = nxt; m_xfer = 1; m_held = 0;
                end
            end else if (m_xfer == 1) begin
                if (ms[o] == 0) begin
                    m_owner = 0; m_xfer = 0; m_held = 0;
                end else if (s_ack_i) begin
                    if (mw[o] == 1 || ma[o] == 3 || ma[o] == 7) m_held = 0;
                    else if (LOCK_EN && (ma[o] == 0 || ma[o] == 4)) m_held = 1;
                    m_xfer = 0;
                    m_quiet = 0;
                    if (m_held == 0) m_owner = 0;
                end
            end else begin
                if (ms[o] == 1) begin
                    m_xfer = 1; m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet >= TMO) begin
                        m_owner = 0; m_held = 0; m_quiet = 0;
                    end
                end
            end
            if (s_stb_o && s_ack_i) begin
                xlog.push_back(int'({gnt_o, s_adr_o}));
                if (rand_mode) sdelay = $urandom_range(0, 3);
            end
            if (s_stb_o && s_ack_i) swait = 0;
            else if (s_stb_o) swait++;
            else swait = 0;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(mq[0].size() == 0 && mq[1].size() == 0 && !act[0] && !act[1] && gnt_o == 2'b00)) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= budget) chk("drain_timeout", n, -1);
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin : watchdog
        repeat (80000) @(posedge wb_clk_i);
        $display("FAIL watchdog: cycle budget exhausted");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : directed
        int g0, g1, a0, a1, k, g, t0, ta, n, m1g, b, n0, n1;
        int e_own[8];
        int e_adr[8];
        txn_t t;

        repeat (3) @(negedge wb_clk_i);
        chk("reset_gnt_lit", int'(gnt_o), 0);
        chk("reset_sstb_lit", int'(s_stb_o), 0);
        chk("reset_ack_lit", int'({m1_ack_o, m0_ack_o}), 0);
        @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);

        // simultaneous requests from reset: m0 first, then m1
        mq[0].push_back(mk(1, 0, 8'h11, 0, 0));
        mq[1].push_back(mk(1, 0, 8'h22, 0, 0));
        g0 = -1; g1 = -1; a0 = -1; a1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            if (gnt_o == 2'b01 && g0 < 0) g0 = i;
            if (gnt_o == 2'b10 && g1 < 0) g1 = i;
            if (m0_ack_o && a0 < 0) a0 = i;
            if (m1_ack_o && a1 < 0) a1 = i;
        end
        chk("rr_m0_gnt_cycle", g0, 1);
        chk("rr_m1_gnt_cycle", g1, 3);
        chk("rr_m0_ack_cycle", a0, 1);
        chk("rr_m1_ack_cycle", a1, 3);
        wait_idle(200);

        // m1 reads bytes 0..3 while m0 strobes continuously
        xlog.delete();
        for (int i = 0; i < 4; i++) mq[1].push_back(mk(i, 0, 0, 0, 0));
        @(negedge wb_clk_i);
        for (int i = 0; i < 4; i++) mq[0].push_back(mk(5, 0, 0, 0, 0));
        wait_idle(300);
        if (LOCK_EN) begin
            e_own = '{2, 2, 2, 2, 1, 1, 1, 1};
            e_adr = '{0, 1, 2, 3, 5, 5, 5, 5};
        end else begin
            e_own = '{2, 1, 2, 1, 2, 1, 2, 1};
            e_adr = '{0, 5, 1, 5, 2, 5, 3, 5};
        end
        chk("seq_len", xlog.size(), 8);
        for (int i = 0; i < 8 && i < xlog.size(); i++) begin
            chk("seq_owner", xlog[i] >> 3, e_own[i]);
            chk("seq_adr", xlog[i] & 7, e_adr[i]);
        end

        // m1 reads address 4 then goes silent: lock timeout
        mq[1].push_back(mk(4, 0, 0, 0, 0));
        @(negedge wb_clk_i);
        mq[0].push_back(mk(5, 0, 0, 0, 0));
        k = -1; g = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge wb_clk_i);
            if (m1_ack_o && k < 0) k = i;
            if (gnt_o == 2'b01 && g < 0) g = i;
        end
        chk("tmo_m1_ack_cycle", k, 0);
        chk("tmo_release_gap", g - k, LOCK_EN ? TMO + 2 : 2);
        wait_idle(200);

        // long blocker write with a stalled slave ack
        sdelay = 120;
        mq[0].push_back(mk(7, 1, 8'h05, 0, 0));
        @(negedge wb_clk_i);
        mq[1].push_back(mk(6, 0, 0, 0, 0));
        t0 = -1; ta = -1; m1g = 0;
        n = 0;
        while (n < 200 && ta < 0) begin
            @(negedge wb_clk_i);
            if (s_stb_o && t0 < 0) t0 = n;
            if (gnt_o == 2'b10) m1g++;
            if (m0_ack_o) begin
                ta = n;
                chk("blk_s_dat", int'(s_dat_o), 5);
                chk("blk_s_we", int'(s_we_o), 1);
                chk("blk_s_adr", int'(s_adr_o), 7);
                chk("blk_s_ack", int'(s_ack_i), 1);
            end
            n++;
        end
        chk("blk_ack_latency", ta - t0, 120);
        chk("blk_m1_waited", m1g, 0);
        sdelay = 0;
        wait_idle(300);

        // reset pulse while m1 holds the slave and m0 is requesting
        sdelay = 5;
        n0 = nack[0]; n1 = nack[1];
        mq[1].push_back(mk(0, 0, 0, 0, 0));
        @(negedge wb_clk_i);
        mq[0].push_back(mk(5, 0, 0, 0, 0));
        k = -1; n = 0;
        while (n < 40 && k < 0) begin
            @(negedge wb_clk_i);
            if (m1_ack_o) k = n;
            n++;
        end
        chk("rst_m1_acked", k >= 0 ? 1 : 0, 1);
        @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_pulse_gnt", int'(gnt_o), 0);
        chk("rst_pulse_ack", int'({m1_ack_o, m0_ack_o}), 0);
        @(negedge wb_clk_i);
        @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        g = -1; n = 0;
        while (n < 30 && g < 0) begin
            @(negedge wb_clk_i);
            if (gnt_o != 2'b00) g = int'(gnt_o);
            n++;
        end
        chk("rst_first_gnt", g, 1);
        wait_idle(200);
        chk("rst_m0_acks", nack[0] - n0, 1);
        chk("rst_m1_acks", nack[1] - n1, 1);

        // owner drops strobe before the slave acks
        sdelay = 10;
        mq[1].push_back(mk(2, 0, 0, 0, 3));
        b = -1; n = 0;
        while (n < 20 && b < 0) begin
            @(negedge wb_clk_i);
            if (gnt_o == 2'b10) b = n;
            n++;
        end
        chk("abort_granted", b >= 0 ? 1 : 0, 1);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("abort_sstb_drop", int'(s_stb_o), 0);
        chk("abort_gnt_held", int'(gnt_o), 2);
        @(negedge wb_clk_i);
        chk("abort_gnt_clear", int'(gnt_o), 0);
        sdelay = 0;
        wait_idle(200);

        // randomized traffic against the model
        rand_mode = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 150; i++) begin
                t = mk(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
                mq[m].push_back(t);
            end
        end
        wait_idle(20000);
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
